lmem_arbiter: RTL and testbench
===============================

# lmem_arbiter

Round-robin arbiter that shares the single-port layer memory (`csel`/`caddr`/`cwr`/`crd`/`cdata_wr`/`cdata_rd`) between three requesters:
- requester 0: the convolution write-back engine
- requester 1: the max-pool engine
- requester 2: the host read-back port

It sits between the layer engines and the layer memory. It registers the winning command onto the memory bus and routes the returned read data back to the issuing requester with a valid strobe. A lock input lets a requester keep the memory for a multi-access burst, such as a 2x2 pooling window.

## Interface
Parameters:
- `AW`, 12: layer-memory address width (64x64 map, `{row,col}`).
- `DW`, 20: data width (signed 4.16 fixed point; not interpreted by this block).

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req`  in  3  per-requester access request; bit i = requester i.
- `lock`  in  3  per-requester burst lock; meaningful only while that requester holds the grant.
- `we`  in  3  per-requester write enable (1 = write, 0 = read).
- `sel`  in  9  packed `csel` values; `sel[3i+2:3i]` belongs to requester i.
- `addr`  in  3*AW  packed addresses; `addr[AW*i +: AW]`.
- `wdata`  in  3*DW  packed write data; `wdata[DW*i +: DW]`.
- `gnt`  out  3  one-hot grant, combinational, same cycle as `req`.
- `rvalid`  out  3  one-hot read-data-valid, registered.
- `rdata`  out  DW  read data, shared by all requesters; valid only with `rvalid`.
- `cwr`  out  1  memory write strobe, registered.
- `crd`  out  1  memory read strobe, registered.
- `csel`  out  3  memory bank select, registered.
- `caddr`  out  AW  memory address, registered; used for both read and write.
- `cdata_wr`  out  DW  memory write data, registered.
- `cdata_rd`  in  DW  memory read data; valid the cycle after `crd`=1.

## Operation
Internal state:
- `ptr[1:0]`: round-robin start index, values 0..2.
- `owner[1:0]` and `locked`: burst owner tracking.
- A two-stage read-tag pipeline.

Winner selection, combinational:
- If `locked`=1, only `owner` may win, and only while `req[owner]`=1. All other requesters get `gnt`=0.
- Otherwise the first i with `req[i]`=1 wins, scanning `ptr`, `ptr+1`, `ptr+2` (mod 3).
- Requesters that are not selected get `gnt[i]`=0. They must hold their request and payload until granted; the arbiter keeps no queue.

State update on a granted cycle (winner w):
- Memory command registers load requester w's fields:
  - `cwr`←`we[w]`, `crd`←`~we[w]`
  - `csel`←`sel[w]`, `caddr`←`addr[w]`, `cdata_wr`←`wdata[w]`
- `lock[w]`=1: `locked`←1, `owner`←w, `ptr` unchanged.
- `lock[w]`=0: `locked`←0, `ptr`←(w+1) mod 3.

State update on a cycle with no grant:
- `cwr`←0 and `crd`←0; `csel`, `caddr`, `cdata_wr` hold their values.
- If `locked` and `req[owner]`=0: `locked`←0 and `ptr`←(owner+1) mod 3.

Other rules:
- `lock` from a requester that does not currently win is ignored.
- A read grant pushes a one-hot tag of w into the read pipeline. A write grant pushes zero.

## Timing
Read path:
- Cycle T: `req[i]`=1 and `gnt[i]`=1.
- Cycle T+1: command on the memory bus (`crd`=1).
- Cycle T+2: `cdata_rd` valid; `rvalid[i]`=1 and `rdata`=`cdata_rd` (`rdata` is a pass-through).
- Read latency is 2 cycles from grant.

Write path: memory write occurs at T+1. No response is returned.

Throughput:
- One access per cycle, back-to-back.
- A locked owner can issue a new access every cycle.
- Reads from different requesters in consecutive cycles return in grant order, one per cycle.

Reset values: all outputs 0 (`gnt` = 0 because `req` = 0 is expected during reset), `ptr`=0, `locked`=0, read pipeline cleared. A reset in the middle of a burst or with a read in flight drops the read: no `rvalid` occurs after reset.

Boundary conditions:
- `ptr` wraps 2→0.
- All three requesting with `ptr`=0 → grant order 0, 1, 2, 0, …
- A requester that releases `lock` in the same cycle as its last access is treated as an unlocked grant.

## Test plan
- Reset, then `req`=3'b111, all reads, no lock, held for 6 cycles → `gnt` sequence 001, 010, 100, 001, 010, 100; `rvalid` follows the same sequence 2 cycles later.
- Requester 1 reads `addr`=12'h041, `sel`=1, with the memory model returning 20'h01234 → `crd`=1 and `caddr`=12'h041 at T+1; `rvalid`=3'b010 and `rdata`=20'h01234 at T+2.
- Requester 1 holds `lock`=1 for a 4-read burst (addresses 0, 1, 64, 65) while requesters 0 and 2 also request → four consecutive grants to 1; then `lock` drops, and the next grant goes to 2, then 0.
- Requester 0 writes `sel`=1, `addr`=12'hFFF, `wdata`=20'h0ABCD → at T+1 `cwr`=1, `crd`=0, `caddr`=12'hFFF, `cdata_wr`=20'h0ABCD; no `rvalid`.
- Locked owner deasserts `req` while another requester is waiting → lock releases with one idle cycle (`cwr`=`crd`=0); the waiting requester is granted the next cycle.
- Assert `reset` one cycle after a read grant → all outputs 0 immediately; no `rvalid` after release; the first grant after reset starts from requester 0.

Source files
------------

// File: rtl/lmem_arbiter_if.sv
// Signal bundle between the layer engines/host and the layer-memory arbiter,
// including the arbiter's registered command port toward the layer memory.
interface lmem_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 20
);
  logic [2:0]      req;
  logic [2:0]      lock;
  logic [2:0]      we;
  logic [8:0]      sel;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt;
  logic [2:0]      rvalid;
  logic [DW-1:0]   rdata;
  logic            cwr;
  logic            crd;
  logic [2:0]      csel;
  logic [AW-1:0]   caddr;
  logic [DW-1:0]   cdata_wr;
  logic [DW-1:0]   cdata_rd;

  modport master (
    output req, lock, we, sel, addr, wdata, cdata_rd,
    input  gnt, rvalid, rdata, cwr, crd, csel, caddr, cdata_wr
  );

  modport slave (
    input  req, lock, we, sel, addr, wdata, cdata_rd,
    output gnt, rvalid, rdata, cwr, crd, csel, caddr, cdata_wr
  );
endinterface

// File: rtl/lmem_arbiter.sv
// Round-robin arbiter sharing the single-port layer memory between the conv
// write-back engine, the max-pool engine and the host read-back port.
module lmem_arbiter #(
  parameter int AW = 12,
  parameter int DW = 20
) (
  input logic          clk,
  input logic          reset,
  lmem_arbiter_if.slave bus
);

  logic [1:0]    ptr;
  logic [1:0]    owner;
  logic          locked;

  logic [1:0]    win;
  logic          win_vld;
  logic          win_we;
  logic          win_lock;
  logic [2:0]    win_sel;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic [2:0]    gnt_w;

  logic          cwr_q;
  logic          crd_q;
  logic [2:0]    csel_q;
  logic [AW-1:0] caddr_q;
  logic [DW-1:0] cdata_wr_q;
  logic [2:0]    tag_s1;
  logic [2:0]    tag_s2;

  function automatic logic [1:0] wrap_inc(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // A held lock pins the grant to its owner; otherwise scan from ptr.
  always_comb begin
    logic [1:0] idx;
    win     = 2'd0;
    win_vld = 1'b0;
    idx     = ptr;
    if (locked) begin
      win     = owner;
      win_vld = bus.req[owner];
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!win_vld && bus.req[idx]) begin
          win     = idx;
          win_vld = 1'b1;
        end
        idx = wrap_inc(idx);
      end
    end
  end

  always_comb begin
    win_we    = 1'b0;
    win_lock  = 1'b0;
    win_sel   = '0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      if (win == i[1:0]) begin
        win_we    = bus.we[i];
        win_lock  = bus.lock[i];
        win_sel   = bus.sel[3*i +: 3];
        win_addr  = bus.addr[AW*i +: AW];
        win_wdata = bus.wdata[DW*i +: DW];
      end
    end
  end

  assign gnt_w = win_vld ? (3'b001 << win) : 3'b000;

  // Command registers hold address/data across idle cycles; only strobes drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cwr_q      <= 1'b0;
      crd_q      <= 1'b0;
      csel_q     <= '0;
      caddr_q    <= '0;
      cdata_wr_q <= '0;
      ptr        <= 2'd0;
      owner      <= 2'd0;
      locked     <= 1'b0;
    end else if (win_vld) begin
      cwr_q      <= win_we;
      crd_q      <= ~win_we;
      csel_q     <= win_sel;
      caddr_q    <= win_addr;
      cdata_wr_q <= win_wdata;
      if (win_lock) begin
        locked <= 1'b1;
        owner  <= win;
      end else begin
        locked <= 1'b0;
        ptr    <= wrap_inc(win);
      end
    end else begin
      cwr_q <= 1'b0;
      crd_q <= 1'b0;
      if (locked && !bus.req[owner]) begin
        locked <= 1'b0;
        ptr    <= wrap_inc(owner);
      end
    end
  end

  // Read tags trail the command by one stage to line up with cdata_rd.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_s1 <= '0;
      tag_s2 <= '0;
    end else begin
      tag_s1 <= (win_vld && !win_we) ? gnt_w : 3'b000;
      tag_s2 <= tag_s1;
    end
  end

  assign bus.gnt      = gnt_w;
  assign bus.rvalid   = tag_s2;
  assign bus.rdata    = bus.cdata_rd;
  assign bus.cwr      = cwr_q;
  assign bus.crd      = crd_q;
  assign bus.csel     = csel_q;
  assign bus.caddr    = caddr_q;
  assign bus.cdata_wr = cdata_wr_q;

endmodule

// File: tb/tb_lmem_arbiter.sv
// Bench for lmem_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a rule-level model.
module tb_lmem_arbiter;
  localparam int AW = 12;
  localparam int DW = 20;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  lmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  lmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] romData(input logic [AW-1:0] a);
    if (a == 12'h041) return 20'h01234;
    return {a, a[7:0]} ^ 20'h5A5A5;
  endfunction

  // Layer memory: registered read, data valid the cycle after crd.
  always @(posedge clk) bus.cdata_rd <= bus.crd ? romData(bus.caddr) : '0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w,
                               input logic [8:0] s, input logic [3*AW-1:0] a, input logic [3*DW-1:0] d);
    @(posedge clk);
    #1;
    bus.req   = r;
    bus.lock  = l;
    bus.we    = w;
    bus.sel   = s;
    bus.addr  = a;
    bus.wdata = d;
  endtask

  typedef struct {
    int            due;
    logic [2:0]    tag;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           rdQ[$];
  int            mPtr = 0;
  int            mOwner = 0;
  bit            mLocked = 1'b0;
  logic          mCwr = 1'b0;
  logic          mCrd = 1'b0;
  logic [2:0]    mCsel = '0;
  logic [AW-1:0] mCaddr = '0;
  logic [DW-1:0] mCdataWr = '0;
  logic [2:0]    modelGnt = '0;

  // Model: winner from the round-robin/lock rules, command one cycle later,
  // read data two cycles later in grant order.
  always @(negedge clk) begin : cmpProc
    int            w;
    logic [2:0]    expRv;
    logic [DW-1:0] expRd;
    if (reset) begin
      mPtr = 0; mOwner = 0; mLocked = 1'b0;
      mCwr = 1'b0; mCrd = 1'b0; mCsel = '0; mCaddr = '0; mCdataWr = '0;
      rdQ.delete();
    end
    w = -1;
    if (mLocked) begin
      if (bus.req[mOwner]) w = mOwner;
    end else begin
      for (int k = 0; k < 3; k++)
        if (w < 0 && bus.req[(mPtr + k) % 3]) w = (mPtr + k) % 3;
    end
    modelGnt = (w >= 0) ? 3'(1 << w) : 3'b000;
    checkOutput("gnt", 64'(bus.gnt), 64'(modelGnt));
    checkOutput("cwr", 64'(bus.cwr), 64'(mCwr));
    checkOutput("crd", 64'(bus.crd), 64'(mCrd));
    checkOutput("csel", 64'(bus.csel), 64'(mCsel));
    checkOutput("caddr", 64'(bus.caddr), 64'(mCaddr));
    checkOutput("cdata_wr", 64'(bus.cdata_wr), 64'(mCdataWr));
    expRv = '0;
    expRd = '0;
    if (rdQ.size() > 0 && rdQ[0].due == cycle) begin
      expRv = rdQ[0].tag;
      expRd = rdQ[0].data;
      void'(rdQ.pop_front());
    end
    checkOutput("rvalid", 64'(bus.rvalid), 64'(expRv));
    if (expRv != 3'b000) checkOutput("rdata", 64'(bus.rdata), 64'(expRd));
    if (!reset) begin
      if (w >= 0) begin
        mCwr     = bus.we[w];
        mCrd     = !bus.we[w];
        mCsel    = bus.sel[3*w +: 3];
        mCaddr   = bus.addr[AW*w +: AW];
        mCdataWr = bus.wdata[DW*w +: DW];
        if (!bus.we[w])
          rdQ.push_back('{due: cycle + 2, tag: 3'(1 << w), data: romData(bus.addr[AW*w +: AW])});
        if (bus.lock[w]) begin
          mLocked = 1'b1;
          mOwner  = w;
        end else begin
          mLocked = 1'b0;
          mPtr    = (w + 1) % 3;
        end
      end else begin
        mCwr = 1'b0;
        mCrd = 1'b0;
        if (mLocked && !bus.req[mOwner]) begin
          mLocked = 1'b0;
          mPtr    = (mOwner + 1) % 3;
        end
      end
    end
    cycle++;
  end

  task automatic randomTraffic(input int nCycles);
    logic [2:0] pend;
    pend = '0;
    for (int c = 0; c < nCycles; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (modelGnt[i]) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 99) < 55) begin
          pend[i] = 1'b1;
          bus.we[i]              = 1'($urandom_range(0, 1));
          bus.sel[3*i +: 3]      = 3'($urandom_range(0, 7));
          bus.addr[AW*i +: AW]   = AW'($urandom);
          bus.wdata[DW*i +: DW]  = DW'($urandom);
        end
        bus.lock[i] = ($urandom_range(0, 99) < 35);
      end
      bus.req = pend;
    end
  endtask

  logic [2:0]  gseq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [11:0] burstAddr [4] = '{12'd0, 12'd1, 12'd64, 12'd65};
  logic [2:0]  burstReq [6] = '{3'b010, 3'b111, 3'b111, 3'b111, 3'b101, 3'b001};
  logic [2:0]  burstLock [6] = '{3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000};
  logic [2:0]  burstGnt [6] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001};

  initial begin
    reset = 1'b1;
    bus.req = '0; bus.lock = '0; bus.we = '0;
    bus.sel = '0; bus.addr = '0; bus.wdata = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_gnt", 64'(bus.gnt), 64'h0);
    checkOutput("reset_rvalid", 64'(bus.rvalid), 64'h0);
    checkOutput("reset_cwr", 64'(bus.cwr), 64'h0);
    checkOutput("reset_crd", 64'(bus.crd), 64'h0);
    checkOutput("reset_caddr", 64'(bus.caddr), 64'h0);
    checkOutput("reset_cdata_wr", 64'(bus.cdata_wr), 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // All three reading, ptr starting at 0.
    for (int c = 0; c < 8; c++) begin
      applyStimulus((c < 6) ? 3'b111 : 3'b000, 3'b000, 3'b000, 9'o210, {12'd7, 12'd6, 12'd5}, '0);
      @(negedge clk);
      if (c < 6) checkOutput("rr_gnt", 64'(bus.gnt), 64'(gseq[c]));
      else       checkOutput("rr_gnt_idle", 64'(bus.gnt), 64'h0);
      if (c >= 2) checkOutput("rr_rvalid", 64'(bus.rvalid), 64'(gseq[c-2]));
    end

    // Single read by requester 1 at 0x041.
    applyStimulus(3'b010, 3'b000, 3'b000, 9'o010, {12'd0, 12'h041, 12'd0}, '0);
    @(negedge clk);
    checkOutput("rd1_gnt", 64'(bus.gnt), 64'h2);
    applyStimulus(3'b000, 3'b000, 3'b000, 9'o010, {12'd0, 12'h041, 12'd0}, '0);
    @(negedge clk);
    checkOutput("rd1_crd", 64'(bus.crd), 64'h1);
    checkOutput("rd1_caddr", 64'(bus.caddr), 64'h041);
    checkOutput("rd1_csel", 64'(bus.csel), 64'h1);
    applyStimulus(3'b000, 3'b000, 3'b000, '0, '0, '0);
    @(negedge clk);
    checkOutput("rd1_rvalid", 64'(bus.rvalid), 64'h2);
    checkOutput("rd1_rdata", 64'(bus.rdata), 64'h01234);

    // Locked 4-read burst by requester 1 while 0 and 2 wait.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(burstReq[k], burstLock[k], 3'b000, 9'o111,
                    {12'h200, (k < 4) ? burstAddr[k] : 12'd0, 12'h100}, '0);
      @(negedge clk);
      checkOutput("burst_gnt", 64'(bus.gnt), 64'(burstGnt[k]));
      if (k >= 1 && k <= 4) checkOutput("burst_caddr", 64'(bus.caddr), 64'(burstAddr[k-1]));
    end

    // Requester 0 write at 0xFFF.
    applyStimulus(3'b001, 3'b000, 3'b001, 9'o001, {12'd0, 12'd0, 12'hFFF}, {20'd0, 20'd0, 20'h0ABCD});
    @(negedge clk);
    checkOutput("wr_gnt", 64'(bus.gnt), 64'h1);
    applyStimulus(3'b000, 3'b000, 3'b000, 9'o001, {12'd0, 12'd0, 12'hFFF}, {20'd0, 20'd0, 20'h0ABCD});
    @(negedge clk);
    checkOutput("wr_cwr", 64'(bus.cwr), 64'h1);
    checkOutput("wr_crd", 64'(bus.crd), 64'h0);
    checkOutput("wr_caddr", 64'(bus.caddr), 64'hFFF);
    checkOutput("wr_cdata", 64'(bus.cdata_wr), 64'h0ABCD);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(3'b000, 3'b000, 3'b000, '0, '0, '0);
      @(negedge clk);
      checkOutput("wr_no_rvalid", 64'(bus.rvalid), 64'h0);
    end

    // Locked owner drops req while requester 2 waits.
    applyStimulus(3'b001, 3'b001, 3'b000, '0, {12'h022, 12'd0, 12'h011}, '0);
    @(negedge clk);
    checkOutput("rel_gnt0", 64'(bus.gnt), 64'h1);
    applyStimulus(3'b100, 3'b000, 3'b000, '0, {12'h022, 12'd0, 12'h011}, '0);
    @(negedge clk);
    checkOutput("rel_idle_gnt", 64'(bus.gnt), 64'h0);
    applyStimulus(3'b100, 3'b000, 3'b000, '0, {12'h022, 12'd0, 12'h011}, '0);
    @(negedge clk);
    checkOutput("rel_gnt2", 64'(bus.gnt), 64'h4);
    checkOutput("rel_idle_cwr", 64'(bus.cwr), 64'h0);
    checkOutput("rel_idle_crd", 64'(bus.crd), 64'h0);
    repeat (3) applyStimulus(3'b000, 3'b000, 3'b000, '0, '0, '0);

    // Reset with a read in flight.
    applyStimulus(3'b010, 3'b000, 3'b000, 9'o070, {12'd0, 12'h123, 12'd0}, '0);
    @(negedge clk);
    checkOutput("rst_rd_gnt", 64'(bus.gnt), 64'h2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.req = '0;
    @(negedge clk);
    checkOutput("rst_crd", 64'(bus.crd), 64'h0);
    checkOutput("rst_caddr", 64'(bus.caddr), 64'h0);
    checkOutput("rst_csel", 64'(bus.csel), 64'h0);
    checkOutput("rst_rvalid", 64'(bus.rvalid), 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("rst_no_rvalid", 64'(bus.rvalid), 64'h0);
      @(posedge clk);
      #1;
    end
    bus.req = 3'b111;
    @(negedge clk);
    checkOutput("rst_first_gnt", 64'(bus.gnt), 64'h1);
    repeat (3) applyStimulus(3'b000, 3'b000, 3'b000, '0, '0, '0);

    $display("[TB] directed scenarios done, starting random traffic");
    randomTraffic(3000);
    repeat (4) applyStimulus(3'b000, 3'b000, 3'b000, '0, '0, '0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
